// File: rtl/gpcore_pkg.sv
// Shared types and constants for the gpcore pipeline.
// Holds the decoded control bundle carried from decode into execute.
package gpcore_pkg;

   localparam int GP_XLEN  = 32;
   localparam int GP_NREGS = 32;

   localparam logic [4:0] REG_X0   = 5'd0;
   localparam logic [3:0] MEM_NONE = 4'd0;
   localparam logic [3:0] MEM_LW   = 4'd3;
   localparam logic [3:0] MEM_SW   = 4'd10;

   localparam logic [2:0] FN_ALU    = 3'd0;
   localparam logic [2:0] FN_PC4    = 3'd1;
   localparam logic [2:0] FN_MULDIV = 3'd2;
   localparam logic [2:0] FN_LUI    = 3'd3;
   localparam logic [2:0] FN_MEM    = 3'd4;
   localparam logic [2:0] FN_AUIPC  = 3'd5;

   typedef struct packed {
      logic [2:0]         fn;
      logic [3:0]         alu_fn;
      logic               bneq;
      logic               btype;
      logic               j;
      logic               jr;
      logic               lui;
      logic               auipc;
      logic [3:0]         mem_op;
      logic [2:0]         muldiv_op;
      logic [1:0]         pcselect;
      logic [GP_XLEN-1:0] bjus_imm;
      logic [GP_XLEN-1:0] pc;
   } issue_ctrl_t;

   // Stores occupy the upper half of the mem_op encoding space.
   function automatic logic is_store(logic [3:0] mop);
      return mop[3];
   endfunction

endpackage

// File: rtl/issue_stage_regfile.sv
// Integer register file: 2 combinational read ports, 1 write port.
// Ports: ra1_i/ra2_i -> rd1_o/rd2_o, write we_i/wa_i/wd_i; x0 reads as 0.
module regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [4:0]      ra1_i,
   input  logic [4:0]      ra2_i,
   output logic [XLEN-1:0] rd1_o,
   output logic [XLEN-1:0] rd2_o,
   input  logic            we_i,
   input  logic [4:0]      wa_i,
   input  logic [XLEN-1:0] wd_i
);

   logic [XLEN-1:0] regs_q [1:NREGS-1];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i && wa_i != 5'd0) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   // Write-through: a same-cycle writeback is visible to the reader.
   function automatic logic [XLEN-1:0] rd_port(logic [4:0] ra);
      if (ra == 5'd0)             return '0;
      else if (we_i && wa_i == ra) return wd_i;
      else                         return regs_q[ra];
   endfunction

   assign rd1_o = rd_port(ra1_i);
   assign rd2_o = rd_port(ra2_i);

endmodule

// File: rtl/issue_stage.sv
// Pipe-4 issue: regfile read, scoreboard hazard stall, operand register.
// In: decode bundle (*3), writeback (*6), flush, memOp_done. Out: pipe-4 (*4).
module issue_stage
   import gpcore_pkg::*;
#(
   parameter int XLEN  = GP_XLEN,
   parameter int NREGS = GP_NREGS
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         dec_valid3,
   output logic                         issue_ready3,
   input  logic [4:0]                   rs1_3,
   input  logic [4:0]                   rs2_3,
   input  logic [4:0]                   rd3,
   input  logic                         we3,
   input  logic                         use_imm3,
   input  logic [XLEN-1:0]              imm3,
   input  logic [$bits(issue_ctrl_t)-1:0] ctrl3,
   input  logic                         flush,
   input  logic [4:0]                   rd6,
   input  logic                         we6,
   input  logic [XLEN-1:0]              wb_data6,
   input  logic                         memOp_done,
   output logic                         valid4,
   output logic [XLEN-1:0]              op_a,
   output logic [XLEN-1:0]              op_b,
   output logic [XLEN-1:0]              store_data4,
   output logic [4:0]                   rd4,
   output logic                         we4,
   output logic [$bits(issue_ctrl_t)-1:0] ctrl4
);

   issue_ctrl_t     c3;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [NREGS-1:0] busy_q, busy_d;
   logic            mem_busy_q, mem_busy_d;
   logic            haz_rs1, haz_rs2, need_rs2, stall, issue;

   logic                          valid4_q, we4_q;
   logic [XLEN-1:0]               op_a_q, op_b_q, sd_q;
   logic [4:0]                    rd4_q;
   logic [$bits(issue_ctrl_t)-1:0] ctrl4_q;

   assign c3 = issue_ctrl_t'(ctrl3);

   regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk   (clk),
      .nrst  (nrst),
      .ra1_i (rs1_3),
      .ra2_i (rs2_3),
      .rd1_o (rs1_val),
      .rd2_o (rs2_val),
      .we_i  (we6),
      .wa_i  (rd6),
      .wd_i  (wb_data6)
   );

   // A busy source is fine if its producer writes back this very cycle.
   always_comb begin
      haz_rs1  = busy_q[rs1_3] && !(we6 && rd6 == rs1_3);
      haz_rs2  = busy_q[rs2_3] && !(we6 && rd6 == rs2_3);
      need_rs2 = !use_imm3 || is_store(c3.mem_op);
      stall    = haz_rs1
               || (need_rs2 && haz_rs2)
               || (we3 && busy_q[rd3])
               || (c3.mem_op != MEM_NONE && mem_busy_q);
   end

   assign issue_ready3 = nrst && !stall && !flush;
   assign issue        = dec_valid3 && issue_ready3;

   // Set after clear so a same-index set wins.
   always_comb begin
      busy_d = busy_q;
      if (we6) busy_d[rd6] = 1'b0;
      if (issue && we3 && rd3 != REG_X0) busy_d[rd3] = 1'b1;
      busy_d[0] = 1'b0;
      mem_busy_d = mem_busy_q;
      if (memOp_done) mem_busy_d = 1'b0;
      if (issue && c3.mem_op != MEM_NONE) mem_busy_d = 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         busy_q     <= '0;
         mem_busy_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         mem_busy_q <= mem_busy_d;
      end
   end

   // Anything that does not issue becomes a fully zeroed bubble.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         valid4_q <= 1'b0;
         we4_q    <= 1'b0;
         rd4_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         sd_q     <= '0;
         ctrl4_q  <= '0;
      end else if (issue) begin
         valid4_q <= 1'b1;
         we4_q    <= we3;
         rd4_q    <= rd3;
         op_a_q   <= rs1_val;
         op_b_q   <= use_imm3 ? imm3 : rs2_val;
         sd_q     <= rs2_val;
         ctrl4_q  <= ctrl3;
      end else begin
         valid4_q <= 1'b0;
         we4_q    <= 1'b0;
         rd4_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         sd_q     <= '0;
         ctrl4_q  <= '0;
      end
   end

   assign valid4      = valid4_q;
   assign we4         = we4_q;
   assign rd4         = rd4_q;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign store_data4 = sd_q;
   assign ctrl4       = ctrl4_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed scenarios then random traffic,
// compared each cycle against an array/flag reference model.
module tb_issue_stage;
   import gpcore_pkg::*;

   localparam int CW = $bits(issue_ctrl_t);

   logic            clk = 1'b0;
   logic            nrst;
   logic            dec_valid3, issue_ready3, we3, use_imm3, flush;
   logic [4:0]      rs1_3, rs2_3, rd3, rd6, rd4;
   logic [31:0]     imm3, wb_data6, op_a, op_b, store_data4;
   logic [CW-1:0]   ctrl3, ctrl4;
   logic            we6, memOp_done, valid4, we4;

   issue_stage dut (
      .clk(clk), .nrst(nrst), .dec_valid3(dec_valid3),
      .issue_ready3(issue_ready3), .rs1_3(rs1_3), .rs2_3(rs2_3),
      .rd3(rd3), .we3(we3), .use_imm3(use_imm3), .imm3(imm3),
      .ctrl3(ctrl3), .flush(flush), .rd6(rd6), .we6(we6),
      .wb_data6(wb_data6), .memOp_done(memOp_done), .valid4(valid4),
      .op_a(op_a), .op_b(op_b), .store_data4(store_data4),
      .rd4(rd4), .we4(we4), .ctrl4(ctrl4)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Reference model state
   logic [31:0]   mreg [32];
   bit            mbusy [32];
   bit            mmem;
   bit            e_ready, e_valid, e_we;
   logic [31:0]   e_opa, e_opb, e_sd;
   logic [4:0]    e_rd;
   logic [CW-1:0] e_ctrl;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mreg[i] = 0; mbusy[i] = 0;
      end
      mmem = 0;
      e_valid = 0; e_we = 0; e_opa = 0; e_opb = 0;
      e_sd = 0; e_rd = 0; e_ctrl = '0;
   endtask

   function automatic logic [31:0] rv(logic [4:0] a);
      if (a == 0) return 0;
      if (we6 && rd6 == a) return wb_data6;
      return mreg[a];
   endfunction

   function automatic bit waits(logic [4:0] a);
      return mbusy[a] && !(we6 && rd6 == a);
   endfunction

   function automatic bit model_ready();
      issue_ctrl_t c;
      bit need2, st;
      c = issue_ctrl_t'(ctrl3);
      need2 = !use_imm3 || (c.mem_op >= 8);
      st = waits(rs1_3) || (need2 && waits(rs2_3))
         || (we3 && mbusy[rd3]) || (c.mem_op != 0 && mmem);
      return nrst && !flush && !st;
   endfunction

   task automatic model_edge();
      issue_ctrl_t c;
      bit iss;
      c = issue_ctrl_t'(ctrl3);
      iss = dec_valid3 && e_ready;
      if (iss) begin
         e_valid = 1; e_we = we3; e_rd = rd3; e_ctrl = ctrl3;
         e_opa = rv(rs1_3);
         e_sd  = rv(rs2_3);
         e_opb = use_imm3 ? imm3 : rv(rs2_3);
      end else begin
         e_valid = 0; e_we = 0; e_rd = 0; e_ctrl = '0;
         e_opa = 0; e_opb = 0; e_sd = 0;
      end
      if (memOp_done) mmem = 0;
      if (iss && c.mem_op != 0) mmem = 1;
      if (we6) mbusy[rd6] = 0;
      if (iss && we3 && rd3 != 0) mbusy[rd3] = 1;
      if (we6 && rd6 != 0) mreg[rd6] = wb_data6;
   endtask

   function automatic logic [31:0] mbusy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = mbusy[i];
      return v;
   endfunction

   task automatic check_state(string p);
      chk({p, "valid4"}, valid4, e_valid);
      chk({p, "we4"}, we4, e_we);
      chk({p, "rd4"}, rd4, e_rd);
      chk({p, "op_a"}, op_a, e_opa);
      chk({p, "op_b"}, op_b, e_opb);
      chk({p, "store_data4"}, store_data4, e_sd);
      chk({p, "ctrl4"}, ctrl4, e_ctrl);
      chk({p, "busy"}, dut.busy_q, mbusy_vec());
      chk({p, "mem_busy"}, dut.mem_busy_q, mmem);
   endtask

   // Inputs are set with clk low; one full cycle is checked.
   task automatic step(string p);
      #1;
      e_ready = model_ready();
      chk({p, "ready"}, issue_ready3, e_ready);
      model_edge();
      @(posedge clk);
      #1;
      check_state(p);
      @(negedge clk);
   endtask

   task automatic idle_in();
      dec_valid3 = 0; rs1_3 = 0; rs2_3 = 0; rd3 = 0; we3 = 0;
      use_imm3 = 0; imm3 = 0; ctrl3 = '0; flush = 0;
      rd6 = 0; we6 = 0; wb_data6 = 0; memOp_done = 0;
   endtask

   task automatic instr(logic [4:0] a, logic [4:0] b, logic [4:0] d,
                        logic w, logic ui, logic [31:0] im,
                        logic [3:0] mop);
      issue_ctrl_t c;
      c = '0;
      c.mem_op = mop;
      c.fn = (mop != 0) ? FN_MEM : FN_ALU;
      dec_valid3 = 1; rs1_3 = a; rs2_3 = b; rd3 = d; we3 = w;
      use_imm3 = ui; imm3 = im; ctrl3 = c;
   endtask

   initial begin
      logic [95:0] r;
      issue_ctrl_t c;
      bit hold;
      idle_in();
      nrst = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", issue_ready3, 1'b0);
      check_state("rst_");
      nrst = 1;

      // addi x1, x0, 5
      instr(0, 0, 1, 1, 1, 32'd5, MEM_NONE);
      step("addi_");
      chk("addi_opb5", op_b, 32'd5);
      // add x2, x1, x1: two stalls, then issue on the writeback cycle
      instr(1, 1, 2, 1, 0, 0, MEM_NONE);
      step("raw1_");
      chk("raw1_stalled", valid4, 1'b0);
      step("raw2_");
      we6 = 1; rd6 = 1; wb_data6 = 32'd5;
      step("rawwb_");
      chk("rawwb_opa5", op_a, 32'd5);
      // write x0 with garbage, read x0 back
      we6 = 1; rd6 = 0; wb_data6 = 32'hDEAD;
      instr(0, 0, 0, 0, 0, 0, MEM_NONE);
      step("x0_");
      chk("x0_opa", op_a, 32'd0);
      we6 = 1; rd6 = 2; wb_data6 = 32'd10;
      // lw x3 then sw held until memOp_done
      instr(1, 0, 3, 1, 1, 32'd4, MEM_LW);
      step("lw_");
      we6 = 0;
      instr(0, 0, 0, 0, 1, 32'd8, MEM_SW);
      step("sw1_");
      step("sw2_");
      memOp_done = 1;
      step("swdone_");
      chk("swdone_stalled", valid4, 1'b0);
      memOp_done = 0;
      step("swiss_");
      chk("swiss_valid", valid4, 1'b1);
      memOp_done = 1; we6 = 1; rd6 = 3; wb_data6 = 32'h33;
      dec_valid3 = 0;
      step("drain_");
      idle_in();
      // flush kills an instruction writing x7
      instr(0, 0, 7, 1, 1, 32'd1, MEM_NONE);
      flush = 1;
      step("flush_");
      chk("flush_busy7", dut.busy_q[7], 1'b0);
      flush = 0;
      // busy x5, stall a reader, reset mid-stall
      instr(0, 0, 5, 1, 1, 32'd9, MEM_NONE);
      step("x5_");
      instr(5, 0, 6, 1, 1, 32'd1, MEM_NONE);
      step("x5stall_");
      nrst = 0;
      #1;
      model_reset();
      chk("mrst_ready", issue_ready3, 1'b0);
      check_state("mrst_");
      #1;
      nrst = 1;
      step("x5after_");
      chk("x5after_valid", valid4, 1'b1);

      // Random traffic, decode holding inputs while not accepted
      idle_in();
      hold = 0;
      for (int n = 0; n < 400; n++) begin
         if (!hold) begin
            r = {$urandom, $urandom, $urandom};
            c = r[CW-1:0];
            case ($urandom_range(0, 3))
               0:       c.mem_op = MEM_LW;
               1:       c.mem_op = MEM_SW;
               default: c.mem_op = MEM_NONE;
            endcase
            dec_valid3 = ($urandom_range(0, 3) != 0);
            rs1_3 = 5'($urandom_range(0, 7));
            rs2_3 = 5'($urandom_range(0, 7));
            rd3 = 5'($urandom_range(0, 7));
            we3 = 1'($urandom);
            use_imm3 = 1'($urandom);
            imm3 = $urandom;
            ctrl3 = c;
         end
         flush = ($urandom_range(0, 7) == 0);
         we6 = 1'($urandom);
         rd6 = 5'($urandom_range(0, 7));
         wb_data6 = $urandom;
         memOp_done = ($urandom_range(0, 3) == 0);
         step("rnd_");
         hold = dec_valid3 && !e_ready;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
